// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared state and priority types for the register-file access arbiter
package rf_arb_pkg;
    typedef enum logic {INIT, RUN} rf_arb_state_t;
    typedef enum logic {PRIO_A, PRIO_B} rf_prio_t;
endpackage

// File: rtl/rf_rr_write_arbiter.sv
// rf_rr_write_arbiter: two-way round-robin write grant; priority flips only on contention
module rf_rr_write_arbiter
    import rf_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);
    rf_prio_t prio;

    // a lone request always wins; on contention the priority holder wins
    always_comb begin
        a_gnt = a_req && (!b_req || prio == PRIO_A);
        b_gnt = b_req && (!a_req || prio == PRIO_B);
    end

    // hand priority to the loser whenever both requesters compete
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio <= PRIO_A;
        else if (a_req && b_req)
            prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
    end
endmodule

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares a 2R/1W register file between two requesters, with zero-fill sweep
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int M  = 32,
    localparam int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    input  logic          a_valid,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [N-1:0]  a_wdata,
    output logic          a_ready,
    output logic          a_rvalid,
    output logic [N-1:0]  a_rdata,
    input  logic          b_valid,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [N-1:0]  b_wdata,
    output logic          b_ready,
    output logic          b_rvalid,
    output logic [N-1:0]  b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_rw,
    output logic [N-1:0]  rf_data_in,
    output logic [AW-1:0] rf_r1,
    output logic [AW-1:0] rf_r2,
    input  logic [N-1:0]  rf_q1,
    input  logic [N-1:0]  rf_q2
);
    rf_arb_state_t state;
    logic [AW-1:0] cnt;
    logic          run_ok;
    logic          a_gnt;
    logic          b_gnt;

    assign run_ok = (state == RUN) && !clr;

    rf_rr_write_arbiter u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .a_req (run_ok && a_valid && a_we),
        .b_req (run_ok && b_valid && b_we),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    // acceptance and register-file port drive; the sweep owns the write port in INIT
    always_comb begin
        a_ready    = run_ok && !(a_valid && a_we && !a_gnt);
        b_ready    = run_ok && !(b_valid && b_we && !b_gnt);
        rf_we      = (state == INIT) || a_gnt || b_gnt;
        rf_rw      = (state == INIT) ? cnt : a_gnt ? a_addr : b_gnt ? b_addr : '0;
        rf_data_in = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
        rf_r1      = a_addr;
        rf_r2      = b_addr;
        a_rdata    = rf_q1;
        b_rdata    = rf_q2;
    end

    // sweep FSM: INIT walks every entry once, clr in RUN starts a new sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == AW'(M - 1)) begin
                state <= RUN;
                cnt   <= '0;
                busy  <= 1'b0;
            end
        end else if (clr) begin
            state <= INIT;
            busy  <= 1'b1;
        end
    end

    // read data arrives one cycle after acceptance, matching the registered RF read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_valid && !a_we && a_ready;
            b_rvalid <= b_valid && !b_we && b_ready;
        end
    end
endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Controller that shares one 2-read/1-write register file (N-bit x M-entry, registered read ports, single write port) between two requesters, A and B.
- After reset, and on request, it sequences a zero-fill sweep of every entry.
- In normal operation it grants reads in parallel (A on read port 1, B on read port 2) and serialises writes with round-robin priority.
- Sits between the two requesters and the register file; it drives all register-file address, data and write-enable inputs.

Parameters:
- N, 32, data width in bits.
- M, 32, number of register-file entries.
- AW, $clog2(M), address width (derived; do not override).

Ports:
- clk  in  1  clock; all logic updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  single-cycle pulse; requests a zero-fill sweep.
- busy  out  1  high while the sweep runs.
- a_valid  in  1  requester A has a request.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  AW  address for A.
- a_wdata  in  N  write data for A.
- a_ready  out  1  A's request is accepted this cycle.
- a_rvalid  out  1  A's read data is valid.
- a_rdata  out  N  A's read data.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as A, for requester B.
- rf_we  out  1  register-file write enable.
- rf_rw  out  AW  register-file write address.
- rf_data_in  out  N  register-file write data.
- rf_r1  out  AW  read address 1 (used by A).
- rf_r2  out  AW  read address 2 (used by B).
- rf_q1  in  N  registered read data 1.
- rf_q2  in  N  registered read data 2.

Behaviour:
- States: INIT and RUN.
- Reset (asynchronous): state=INIT, sweep counter=0, prio=A, busy=1, a_rvalid=b_rvalid=0.
- Reset during a sweep restarts the sweep at address 0.
- INIT:
  - rf_we=1, rf_rw=counter, rf_data_in=0.
  - a_ready=b_ready=0, busy=1.
  - Counter increments each cycle. At counter==M-1, next state is RUN and the counter returns to 0.
  - The sweep takes exactly M cycles. clr is ignored during INIT.
- RUN:
  - busy=0.
  - If clr=1: next state is INIT, a_ready=b_ready=0 this cycle, and no request is accepted.
- Acceptance (RUN, clr=0), decided combinationally:
  - Any valid read is accepted, and both reads may be accepted in the same cycle.
  - A single valid write is accepted.
  - If both requesters present writes, only the requester holding prio is accepted. prio then flips to the other requester. prio does not change in any other case.
  - A read and a write are both accepted in the same cycle.
- Port drive:
  - rf_r1=a_addr and rf_r2=b_addr at all times in RUN.
  - rf_we=1 only for an accepted write, with rf_rw and rf_data_in taken from the winner.
  - When idle, rf_we=0 and rf_rw and rf_data_in are held at 0.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester must hold valid, we, addr and wdata stable until ready=1.
  - ready may be high while valid is low; this has no effect.
- Read latency: an accepted read in cycle t gives x_rvalid=1 in cycle t+1, registered. x_rdata=rf_q1 (for A) or rf_q2 (for B) in that cycle.
- Writes produce no response.
- Same-address collisions in one cycle:
  - A read and a write to the same address in the same cycle returns the old data; the register file reads before it writes.
  - A write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
- Both requesters reading the same address is legal; both return the same data.
- rvalid is 0 during INIT and in the first RUN cycle unless a read was accepted in the cycle before.

Decomposition:
- Package rf_arb_pkg:
  - typedef enum logic {INIT, RUN} rf_arb_state_t;
  - typedef enum logic {PRIO_A, PRIO_B} rf_prio_t.
- One sub-module, rf_rr_write_arbiter: 2-way round-robin grant with the prio flop.
- The sweep FSM, read path and port muxing stay in the top.

Test Plan:
- Reset, then hold a_valid=b_valid=0 → busy=1 and rf_we=1 for exactly 32 cycles, covering addresses 0..31 with data 0. busy=0 in cycle 33. Reading any address returns 0.
- A writes 0xDEADBEEF to address 5; the next cycle A reads address 5 → a_rvalid=1 one cycle after acceptance with a_rdata=0xDEADBEEF.
- A and B both write continuously (A: address 3, 0x11; B: address 3, 0x22) → grants alternate A, B, A, B starting with A after reset. The loser holds its request with ready=0. Final content of address 3 matches the last grant.
- In the same cycle, A reads address 7 (old value 0x0) while B writes 0x77 to address 7 → both are accepted, a_rdata=0x0. A re-read the next cycle returns 0x77.
- Pulse clr while both requesters are issuing reads → no acceptance that cycle, then a 32-cycle sweep with a_ready=b_ready=0. After the sweep, every address reads 0.
- Assert reset at sweep address 10 → busy stays high, and the sweep restarts from address 0 and runs a full 32 cycles.
